// File: rtl/oa_tx_if.sv
// oa_tx_if: register-file fetch port and UART/status signals of the frame transmitter.
// master = transmitter side, slave = register file / host side.
interface oa_tx_if #(parameter int IDX_W = 6) ();
    logic             start;
    logic [IDX_W-1:0] fetch_idx;
    logic [7:0]       fetch_data;
    logic             tx;
    logic             busy;
    logic             byte_done;
    logic             done;
    modport master (input start, fetch_data, output fetch_idx, tx, busy, byte_done, done);
    modport slave  (output start, fetch_data, input fetch_idx, tx, busy, byte_done, done);
endinterface

// File: rtl/oa_tx.sv
// oa_tx: reads NUM_BYTES register-file bytes and sends them as 8N1 UART, LSB first.
// Define OA_TX_CHECKSUM_EN to append a mod-256 sum byte after the payload.
module oa_tx #(
    parameter int CLK_DIV   = 434,
    parameter int NUM_BYTES = 55,
    parameter int IDX_W     = 6
) (
    input logic    clk,
    input logic    reset,
    oa_tx_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START_BIT, DATA, STOP_BIT, NEXT} state_t;
    state_t           state, state_n;
    logic [15:0]      baud, baud_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             tx, tx_n, busy, busy_n, byte_done, byte_done_n, done, done_n;
    logic             baud_end, last_idx, last_byte;
`ifdef OA_TX_CHECKSUM_EN
    logic [7:0]       sum, sum_n;
    logic             chk, chk_n;
    assign last_byte = last_idx && chk;
`else
    assign last_byte = last_idx;
`endif
    assign baud_end = baud == 16'(CLK_DIV - 1);
    assign last_idx = idx == IDX_W'(NUM_BYTES - 1);
    assign bus.fetch_idx = idx;
    assign bus.tx        = tx;
    assign bus.busy      = busy;
    assign bus.byte_done = byte_done;
    assign bus.done      = done;
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        idx_n       = idx;
        busy_n      = busy;
        byte_done_n = 1'b0;
        done_n      = 1'b0;
        baud_n      = (state == START_BIT || state == DATA || state == STOP_BIT) ?
                      (baud_end ? 16'd0 : baud + 16'd1) : baud;
        // tx is registered, so the line lags the state by one cycle
        tx_n        = state == START_BIT ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`ifdef OA_TX_CHECKSUM_EN
        sum_n       = sum;
        chk_n       = chk;
`endif
        case (state)
            IDLE: if (bus.start) begin
                state_n = FETCH;
                idx_n   = '0;
                busy_n  = 1'b1;
`ifdef OA_TX_CHECKSUM_EN
                sum_n   = 8'd0;
                chk_n   = 1'b0;
`endif
            end
            FETCH: state_n = LOAD;
            LOAD: begin
`ifdef OA_TX_CHECKSUM_EN
                shift_n = chk ? sum : bus.fetch_data;
                sum_n   = sum + bus.fetch_data;
`else
                shift_n = bus.fetch_data;
`endif
                baud_n  = 16'd0;
                state_n = START_BIT;
            end
            START_BIT: if (baud_end) begin
                bit_cnt_n = 3'd0;
                state_n   = DATA;
            end
            DATA: if (baud_end) begin
                shift_n   = shift >> 1;
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = STOP_BIT;
            end
            STOP_BIT: if (baud_end) begin
                byte_done_n = 1'b1;
                state_n     = NEXT;
            end
            NEXT: begin
                state_n = FETCH;
                if (last_byte) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (last_idx) begin
`ifdef OA_TX_CHECKSUM_EN
                    chk_n   = 1'b1;
`endif
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud      <= 16'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            idx       <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
            done      <= 1'b0;
`ifdef OA_TX_CHECKSUM_EN
            sum       <= 8'd0;
            chk       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            idx       <= idx_n;
            tx        <= tx_n;
            busy      <= busy_n;
            byte_done <= byte_done_n;
            done      <= done_n;
`ifdef OA_TX_CHECKSUM_EN
            sum       <= sum_n;
            chk       <= chk_n;
`endif
        end
    end
endmodule
